// File: rtl/lcd_text_engine.sv
// lcd_text_engine: HD44780-class character LCD driver for a ROWS x COLS display.
// Runs the power-up wait and init commands, then redraws the whole display from
// a frame buffer that is snapshotted from iSymbols at the start of every frame.
// Every byte goes through one write sub-sequencer: SETUP, EN pulse, HOLD, WAIT.
module lcd_text_engine #(
  parameter int ROWS       = 2,
  parameter int COLS       = 16,
  parameter int PWR_WAIT   = 750000,
  parameter int EN_CYCLES  = 16,
  parameter int GAP_CYCLES = 2500,
  parameter int CLR_CYCLES = 100000
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [ROWS*COLS*8-1:0] iSymbols,
  input  logic                   iAuto,
  input  logic                   iUpdate,
  output logic                   oBusy,
  output logic                   oFrameDone,
  output logic [7:0]             LCD_DATA,
  output logic                   LCD_RW,
  output logic                   LCD_EN,
  output logic                   LCD_RS
);

  localparam int NCHR = ROWS * COLS;
  localparam int IW   = $clog2(NCHR);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_SNAP, S_ADDR, S_CHAR
  } state_t;

  typedef enum logic [1:0] {
    W_SETUP, W_PULSE, W_HOLD, W_WAIT
  } wphase_t;

  state_t          r_state;
  wphase_t         r_wphase;
  logic [31:0]     r_cnt;
  logic [1:0]      r_init_idx;
  logic [1:0]      r_row;
  logic [4:0]      r_col;
  logic [IW-1:0]   r_char_idx;
  logic            r_pending;
  logic            r_busy;
  logic            r_done;
  logic [7:0]      r_lcd_data;
  logic            r_lcd_en;
  logic            r_lcd_rs;
  logic [7:0]      r_frame [NCHR];

  logic [7:0]      w_sym [NCHR];
  logic [31:0]     w_wait_len;
  logic            w_go;
  logic [IW-1:0]   w_char_next;

  // Init command bytes: function set 8-bit/2-line, display on, clear, entry mode.
  function automatic logic [7:0] f_init_byte(input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = 8'h38;
      2'd1:    b = 8'h0C;
      2'd2:    b = 8'h01;
      default: b = 8'h06;
    endcase
    return b;
  endfunction

  // Set-DDRAM command for a row: odd rows at 0x40, rows 2/3 shifted by COLS.
  function automatic logic [7:0] f_row_cmd(input logic [1:0] row);
    logic [7:0] a;
    a = row[0] ? 8'h40 : 8'h00;
    if (row[1]) a = a + 8'(COLS);
    return 8'h80 | a;
  endfunction

  // Unpack the flat text vector: character 0 (row 0, col 0) is the MSB byte.
  for (genvar gi = 0; gi < NCHR; gi++) begin : g_unpack
    assign w_sym[gi] = iSymbols[(NCHR-1-gi)*8 +: 8];
  end

  // The clear command needs the long settle time; every other byte uses the gap.
  assign w_wait_len  = (r_lcd_data == 8'h01 && !r_lcd_rs) ? 32'(CLR_CYCLES) : 32'(GAP_CYCLES);
  // A pending request is honoured even with iAuto=0; a fresh iUpdate only counts when idle.
  assign w_go        = iAuto || r_pending || (iUpdate && !r_busy);
  assign w_char_next = r_char_idx + 1'b1;

  assign oBusy      = r_busy;
  assign oFrameDone = r_done;
  assign LCD_DATA   = r_lcd_data;
  assign LCD_RW     = 1'b0;
  assign LCD_EN     = r_lcd_en;
  assign LCD_RS     = r_lcd_rs;

  // Frame buffer: whole-frame snapshot taken in the single SNAP cycle.
  always_ff @(posedge iCLK) begin
    if (r_state == S_SNAP) begin
      for (int i = 0; i < NCHR; i++) r_frame[i] <= w_sym[i];
    end
  end

  // Main FSM with the embedded byte-write sub-sequencer and registered LCD outputs.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      r_state    <= S_PWR;
      r_wphase   <= W_SETUP;
      r_cnt      <= '0;
      r_init_idx <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_char_idx <= '0;
      r_pending  <= 1'b0;
      r_busy     <= 1'b1;
      r_done     <= 1'b0;
      r_lcd_data <= 8'h00;
      r_lcd_en   <= 1'b0;
      r_lcd_rs   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      // Starting a frame absorbs any outstanding request; otherwise a busy-time
      // request is remembered (depth one, later ones merge).
      if (r_state == S_IDLE && w_go)
        r_pending <= 1'b0;
      else if (iUpdate && r_busy)
        r_pending <= 1'b1;

      case (r_state)
        S_PWR: begin
          if (r_cnt + 32'd1 >= 32'(PWR_WAIT)) begin
            r_state    <= S_INIT;
            r_cnt      <= '0;
            r_init_idx <= 2'd0;
            r_wphase   <= W_SETUP;
            r_lcd_data <= f_init_byte(2'd0);
            r_lcd_rs   <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end

        S_IDLE: begin
          if (w_go) begin
            r_state <= S_SNAP;
            r_busy  <= 1'b1;
          end else begin
            r_busy  <= 1'b0;
          end
        end

        S_SNAP: begin
          r_state    <= S_ADDR;
          r_row      <= 2'd0;
          r_char_idx <= '0;
          r_cnt      <= '0;
          r_wphase   <= W_SETUP;
          r_lcd_data <= f_row_cmd(2'd0);
          r_lcd_rs   <= 1'b0;
        end

        S_INIT, S_ADDR, S_CHAR: begin
          case (r_wphase)
            W_SETUP: begin
              r_lcd_en <= 1'b1;
              r_cnt    <= '0;
              r_wphase <= W_PULSE;
            end
            W_PULSE: begin
              if (r_cnt + 32'd1 >= 32'(EN_CYCLES)) begin
                r_lcd_en <= 1'b0;
                r_cnt    <= '0;
                r_wphase <= W_HOLD;
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
            W_HOLD: begin
              r_cnt    <= '0;
              r_wphase <= W_WAIT;
            end
            default: begin
              if (r_cnt + 32'd1 >= w_wait_len) begin
                // Byte finished: load the next one so it is valid from its SETUP cycle.
                r_cnt    <= '0;
                r_wphase <= W_SETUP;
                case (r_state)
                  S_INIT: begin
                    if (r_init_idx == 2'd3) begin
                      r_state <= S_IDLE;
                    end else begin
                      r_init_idx <= r_init_idx + 2'd1;
                      r_lcd_data <= f_init_byte(r_init_idx + 2'd1);
                      r_lcd_rs   <= 1'b0;
                    end
                  end
                  S_ADDR: begin
                    r_state    <= S_CHAR;
                    r_col      <= 5'd0;
                    r_lcd_data <= r_frame[r_char_idx];
                    r_lcd_rs   <= 1'b1;
                  end
                  default: begin
                    if (r_col != 5'(COLS-1)) begin
                      r_col      <= r_col + 5'd1;
                      r_char_idx <= w_char_next;
                      r_lcd_data <= r_frame[w_char_next];
                    end else if (r_row != 2'(ROWS-1)) begin
                      r_row      <= r_row + 2'd1;
                      r_char_idx <= w_char_next;
                      r_state    <= S_ADDR;
                      r_lcd_data <= f_row_cmd(r_row + 2'd1);
                      r_lcd_rs   <= 1'b0;
                    end else begin
                      r_state <= S_IDLE;
                      r_done  <= 1'b1;
                    end
                  end
                endcase
              end else begin
                r_cnt <= r_cnt + 32'd1;
              end
            end
          endcase
        end

        default: begin
          r_state <= S_PWR;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_text_engine.sv
// tb_lcd_text_engine: directed bench for lcd_text_engine in a 16x2 and a 20x4 build.
// LCD writes are captured on each LCD_EN falling edge and compared to hand-built tables.
`timescale 1ns/1ps
module tb_lcd_text_engine;

  localparam int PW  = 10;
  localparam int ENC = 2;
  localparam int GAP = 3;
  localparam int CLR = 8;
  localparam int WR  = 2 + ENC + GAP;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16x2 instance
  logic         rst_n, auto_m, upd;
  logic [255:0] sym;
  logic         busy, fdone, lrw, len, lrs;
  logic [7:0]   ldata;

  lcd_text_engine #(.ROWS(2), .COLS(16), .PWR_WAIT(PW), .EN_CYCLES(ENC),
                    .GAP_CYCLES(GAP), .CLR_CYCLES(CLR)) dut (
    .iCLK(clk), .iRST_N(rst_n), .iSymbols(sym), .iAuto(auto_m), .iUpdate(upd),
    .oBusy(busy), .oFrameDone(fdone), .LCD_DATA(ldata), .LCD_RW(lrw),
    .LCD_EN(len), .LCD_RS(lrs));

  // 20x4 instance
  logic         rst4_n, auto4, upd4;
  logic [639:0] sym4;
  logic         busy4, fdone4, lrw4, len4, lrs4;
  logic [7:0]   ldata4;

  lcd_text_engine #(.ROWS(4), .COLS(20), .PWR_WAIT(PW), .EN_CYCLES(ENC),
                    .GAP_CYCLES(GAP), .CLR_CYCLES(CLR)) dut4 (
    .iCLK(clk), .iRST_N(rst4_n), .iSymbols(sym4), .iAuto(auto4), .iUpdate(upd4),
    .oBusy(busy4), .oFrameDone(fdone4), .LCD_DATA(ldata4), .LCD_RW(lrw4),
    .LCD_EN(len4), .LCD_RS(lrs4));

  typedef struct {
    logic       rs;
    logic [7:0] data;
    int         hi;
    int         lo;
    int         rise;
  } cap_t;

  cap_t cap_q[$];
  cap_t cap4_q[$];

  int checks = 0;
  int errors = 0;
  int rel_cyc = 0;

  // Cycles since reset release of the 16x2 instance
  always @(posedge clk) begin
    if (!rst_n) rel_cyc <= 0;
    else        rel_cyc <= rel_cyc + 1;
  end

  // Write monitor for 16x2: EN high/low run lengths and the byte on each EN fall
  logic en_q = 1'b0;
  int   hi_run = 0, lo_run = 0, cur_lo = 0, cur_rise = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      en_q = 1'b0; hi_run = 0; lo_run = 0;
    end else begin
      if (len) begin
        if (!en_q) begin cur_lo = lo_run; cur_rise = rel_cyc; end
        hi_run++;
      end else begin
        if (en_q) begin
          cap_q.push_back('{lrs, ldata, hi_run, cur_lo, cur_rise});
          hi_run = 0; lo_run = 0;
        end
        lo_run++;
      end
      en_q = len;
    end
  end

  // Write monitor for 20x4: bytes only
  logic en4_q = 1'b0;
  always @(negedge clk) begin
    if (!rst4_n) en4_q = 1'b0;
    else begin
      if (en4_q && !len4) cap4_q.push_back('{lrs4, ldata4, 0, 0, 0});
      en4_q = len4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_caps(input int n, input int bound, input string name);
    int k;
    k = 0;
    while (cap_q.size() < n && k < bound) begin @(negedge clk); k++; end
    chk({name, "_count"}, 32'(cap_q.size() >= n), 32'd1);
  endtask

  task automatic check_init(input string name);
    logic [8:0] exp_b [4];
    logic [8:0] got;
    exp_b[0] = 9'h038; exp_b[1] = 9'h00C; exp_b[2] = 9'h001; exp_b[3] = 9'h006;
    wait_caps(4, 300, name);
    for (int j = 0; j < 4; j++) begin
      got = 'x;
      if (j < cap_q.size()) got = {cap_q[j].rs, cap_q[j].data};
      chk($sformatf("%s_byte%0d", name, j), 32'(got), 32'(exp_b[j]));
      if (j < cap_q.size()) chk($sformatf("%s_en_hi%0d", name, j), cap_q[j].hi, ENC);
    end
    if (cap_q.size() >= 4) begin
      chk({name, "_first_rise_ge11"}, 32'(cap_q[0].rise >= 11), 32'd1);
      chk({name, "_gap_before_clr"}, cap_q[2].lo, 1 + GAP + 1);
      chk({name, "_gap_after_clr"},  cap_q[3].lo, 1 + CLR + 1);
    end
  endtask

  typedef struct {
    string        name;
    logic [255:0] syms;
    logic [255:0] mid;
    bit           do_mid;
    logic [255:0] exp_txt;
  } fvec_t;

  initial begin
    fvec_t        vt [4];
    logic [127:0] r0, r1;
    logic [255:0] hello, zz, ones;
    logic [8:0]   exp_b, got;
    int           t0, t1, nd, k;
    int           dts [$];
    logic [7:0]   cmd4 [4];

    r0 = "HELLO WORLD     ";
    r1 = "0123456789ABCDEF";
    hello = {r0, r1};
    zz    = {32{8'h5A}};
    ones  = {32{8'h01}};
    vt[0] = '{"hello",    hello, '0, 1'b0, hello};
    vt[1] = '{"snap_mid", hello, zz, 1'b1, hello};
    vt[2] = '{"next_z",   zz,    '0, 1'b0, zz};
    vt[3] = '{"char_01",  ones,  '0, 1'b0, ones};

    rst_n = 1'b0; rst4_n = 1'b0; sym = '0; sym4 = '0;
    auto_m = 1'b0; auto4 = 1'b0; upd = 1'b0; upd4 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_data", 32'(ldata), 32'h00);
    chk("rst_en",   32'(len),   32'd0);
    chk("rst_rs",   32'(lrs),   32'd0);
    chk("rst_rw",   32'(lrw),   32'd0);
    chk("rst_busy", 32'(busy),  32'd1);
    chk("rst_done", 32'(fdone), 32'd0);

    // Power-up and init sequence
    rst_n = 1'b1; rst4_n = 1'b1;
    check_init("init");
    k = 0;
    while (busy && k < 100) begin @(negedge clk); k++; end
    chk("idle_after_init", 32'(busy), 32'd0);

    // Table-driven 16x2 frames, iAuto=0, one iUpdate each
    for (int i = 0; i < 4; i++) begin
      cap_q.delete();
      sym = vt[i].syms;
      upd = 1'b1;
      t0  = rel_cyc;
      @(negedge clk);
      upd = 1'b0;
      nd = 0; t1 = 0;
      for (int c = 0; c < 300; c++) begin
        if (fdone) begin
          if (nd == 0) t1 = rel_cyc;
          nd++;
        end
        if (c == 100) begin
          chk({vt[i].name, "_busy_mid"}, 32'(busy), 32'd1);
          if (vt[i].do_mid) sym = vt[i].mid;
        end
        @(negedge clk);
      end
      chk({vt[i].name, "_ndone"}, nd, 1);
      chk({vt[i].name, "_len"}, t1 - t0 - 1, 1 + 2 * 17 * WR);
      chk({vt[i].name, "_nbytes"}, cap_q.size(), 34);
      chk({vt[i].name, "_busy_end"}, 32'(busy), 32'd0);
      for (int j = 0; j < 34; j++) begin
        if (j == 0)       exp_b = 9'h080;
        else if (j == 17) exp_b = 9'h0C0;
        else begin
          int ci;
          ci = (j < 17) ? j - 1 : j - 2;
          exp_b = {1'b1, vt[i].exp_txt[(31 - ci) * 8 +: 8]};
        end
        got = 'x;
        if (j < cap_q.size()) got = {cap_q[j].rs, cap_q[j].data};
        chk($sformatf("%s_b%0d", vt[i].name, j), 32'(got), 32'(exp_b));
      end
    end

    // Continuous redraw: one IDLE cycle between frames
    auto_m = 1'b1;
    sym = hello;
    for (int c = 0; c < 700 && dts.size() < 2; c++) begin
      if (fdone) dts.push_back(rel_cyc);
      @(negedge clk);
    end
    auto_m = 1'b0;
    chk("auto_frames_seen", dts.size(), 2);
    if (dts.size() == 2) chk("auto_spacing", dts[1] - dts[0], 1 + 1 + 2 * 17 * WR);
    k = 0;
    while (busy && k < 400) begin @(negedge clk); k++; end
    chk("auto_stop_idle", 32'(busy), 32'd0);

    // Request merging: start, two mid-frame requests, one on the oFrameDone cycle
    cap_q.delete();
    nd = 0;
    for (int c = 0; c < 800; c++) begin
      upd = (c == 0) || (c == 50) || (c == 120) || (fdone && nd == 0);
      if (fdone) nd++;
      @(negedge clk);
    end
    upd = 1'b0;
    chk("merge_frames", nd, 2);
    chk("merge_bytes", cap_q.size(), 68);
    chk("merge_idle_busy", 32'(busy), 32'd0);

    // Reset while LCD_EN is high
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    k = 0;
    while (!len && k < 50) begin @(negedge clk); k++; end
    chk("midrst_en_seen", 32'(len), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_en",   32'(len),   32'd0);
    chk("midrst_data", 32'(ldata), 32'h00);
    chk("midrst_rs",   32'(lrs),   32'd0);
    chk("midrst_busy", 32'(busy),  32'd1);
    chk("midrst_done", 32'(fdone), 32'd0);
    @(negedge clk);
    cap_q.delete();
    rst_n = 1'b1;
    check_init("reinit");

    // 20x4 frame: row addresses 0x80, 0xC0, 0x94, 0xD4
    cmd4[0] = 8'h80; cmd4[1] = 8'hC0; cmd4[2] = 8'h94; cmd4[3] = 8'hD4;
    for (int c = 0; c < 80; c++) sym4[(79 - c) * 8 +: 8] = 8'h41 + 8'(c % 26);
    k = 0;
    while (busy4 && k < 200) begin @(negedge clk); k++; end
    cap4_q.delete();
    upd4 = 1'b1;
    @(negedge clk);
    upd4 = 1'b0;
    k = 0;
    while (!fdone4 && k < 800) begin @(negedge clk); k++; end
    chk("r4_done", 32'(fdone4), 32'd1);
    @(negedge clk);
    chk("r4_nbytes", cap4_q.size(), 84);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c <= 20; c++) begin
        int j;
        j = r * 21 + c;
        if (c == 0) exp_b = {1'b0, cmd4[r]};
        else        exp_b = {1'b1, 8'h41 + 8'((r * 20 + c - 1) % 26)};
        got = 'x;
        if (j < cap4_q.size()) got = {cap4_q[j].rs, cap4_q[j].data};
        chk($sformatf("r4_b%0d", j), 32'(got), 32'(exp_b));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_text_engine.md
# lcd_text_engine

Parametrised HD44780-class character-LCD engine: the next generation of our fixed 16x2 ASCII display driver, with the bus-timing controller folded in. Drives a ROWS x COLS display from a flat ASCII vector and snapshots the whole frame at frame start so a redraw never mixes two frames. Supports continuous redraw or on-demand redraw. Sits between CPU debug/status logic and the board LCD pins.

## Interface
- ROWS, 2, display rows; legal 1, 2, 4
- COLS, 16, characters per row; legal 8..20
- PWR_WAIT, 750000, cycles held idle after reset before the first command
- EN_CYCLES, 16, cycles LCD_EN stays high per write
- GAP_CYCLES, 2500, idle cycles after each write before the next
- CLR_CYCLES, 100000, idle cycles after the clear command (0x01), replacing GAP_CYCLES
- iCLK  in  1  clock; all logic is on its rising edge
- iRST_N  in  1  reset, synchronous, active-low
- iSymbols  in  ROWS*COLS*8  ASCII text; row 0 col 0 = MSB byte, row-major, last row's last column = bits [7:0]
- iAuto  in  1  1 = redraw continuously; 0 = redraw only on request
- iUpdate  in  1  1-cycle redraw request; used only when iAuto=0
- oBusy  out  1  high from snapshot through the last character write of a frame, and during init
- oFrameDone  out  1  1-cycle pulse when a frame's last character write (including its gap) finishes
- LCD_DATA  out  8  LCD data bus
- LCD_RW  out  1  tied 0 (write only)
- LCD_EN  out  1  LCD enable strobe
- LCD_RS  out  1  0 = command, 1 = character data

## Operation
- Main FSM states: PWR, INIT, IDLE, SNAP, ADDR, CHAR.
- PWR: count PWR_WAIT cycles, then go to INIT.
- INIT: write 0x38, 0x0C, 0x01, 0x06, all with RS=0, then go to IDLE.
- IDLE:
  - If iAuto=1, go to SNAP immediately.
  - If iAuto=0, go to SNAP on iUpdate.
  - An iUpdate arriving while oBusy=1 sets a pending flag (depth 1; further requests merge). The pending flag forces one more frame at the next IDLE.
- SNAP: copy iSymbols into an internal frame buffer in one cycle. Set row=0.
- ADDR: write the set-DDRAM command 0x80 | addr(row) with RS=0.
  - addr(row) = (row[0] ? 0x40 : 0x00) + (row[1] ? COLS : 0).
  - This gives 0x00/0x40/0x14/0x54 for 20x4, and 0x00/0x40 for 2-row displays.
- CHAR: write COLS bytes from the buffer with RS=1, col 0..COLS-1. Then:
  - row < ROWS-1: increment row and return to ADDR.
  - row = ROWS-1: pulse oFrameDone and return to IDLE.
- Write sub-sequencer, for every byte:
  - SETUP, 1 cycle: drive LCD_DATA/LCD_RS, EN=0.
  - PULSE, EN_CYCLES cycles: EN=1.
  - HOLD, 1 cycle: EN=0, data held.
  - WAIT: GAP_CYCLES cycles, or CLR_CYCLES if the byte was command 0x01.
- LCD_DATA and LCD_RS stay stable from SETUP through the end of WAIT.
- iSymbols changes after SNAP have no effect until the next frame.

## Timing
- Reset values: LCD_DATA=0x00, LCD_EN=0, LCD_RS=0, LCD_RW=0, oBusy=1, oFrameDone=0. FSM=PWR, all counters 0, pending=0.
- Reset asserted mid-write drops LCD_EN on the next edge and restarts from PWR.
- One write = 2 + EN_CYCLES + wait cycles, where wait = GAP_CYCLES or CLR_CYCLES.
- Frame length, SNAP to oFrameDone: 1 + ROWS*(COLS+1)*(2+EN_CYCLES+GAP_CYCLES) cycles.
- In iAuto=1 mode, IDLE lasts 1 cycle between frames.
- In iAuto=0 mode, iUpdate in IDLE enters SNAP on the next edge.
- If iUpdate coincides with the oFrameDone cycle, it sets pending and is not lost.
- oBusy drops in the IDLE cycle after oFrameDone. It stays low while waiting in IDLE with iAuto=0.

## Test plan
- Use a reduced bench configuration: PWR_WAIT=10, EN_CYCLES=2, GAP_CYCLES=3, CLR_CYCLES=8.
- Reset/init: release reset, capture bytes on each LCD_EN falling edge.
  - Required: 0x38, 0x0C, 0x01, 0x06, all RS=0; the first LCD_EN rise is no earlier than cycle 11.
  - Required: 8 idle cycles after 0x01; EN high exactly 2 cycles per write.
- 16x2 frame, iAuto=0, row 0 "HELLO WORLD     " and row 1 "0123456789ABCDEF", iUpdate pulse.
  - Required sequence: 0x80, 16 row-0 chars with RS=1, 0xC0, 16 row-1 chars.
  - Required: oFrameDone exactly once, 1 + 2*17*7 = 239 cycles after SNAP.
- ROWS=4, COLS=20: row command bytes are 0x80, 0xC0, 0x94, 0xD4, each followed by 20 chars.
- Snapshot: change iSymbols to all 'Z' (0x5A) mid-frame; the rest of that frame still shows the original text, and the next frame shows 'Z'.
- Request merging, iAuto=0: issue three iUpdate pulses during one frame, one of them on the oFrameDone cycle.
  - Required: exactly one extra frame follows, then oBusy=0 and the engine stays idle.
- Reset mid-write: assert iRST_N=0 while LCD_EN=1.
  - Required: EN=0 and outputs at reset values on the next edge, and a full init sequence repeats after release.
